// File: rtl/herald_result_reader.sv
// herald_result_reader: fetches one accelerator result word and streams it to the host byte by byte
module herald_result_reader #(
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                rdy_get,
  input  logic [RESULT_W-1:0] get_data,
  output logic                en_get,
  input  logic                msb_first,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ack,
  output logic                frame_start,
  output logic                busy,
  output logic [7:0]          frame_cnt,
  output logic                aborted
);
  localparam int NBYTES = RESULT_W / 8;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  logic [RESULT_W-1:0] r_shift;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_byte_out;
  logic                r_byte_valid;
  logic                r_frame_start;
  logic                r_busy;
  logic [7:0]          r_frame_cnt;
  logic                r_aborted;
  logic [RESULT_W-1:0] w_rev;
  logic [RESULT_W-1:0] w_ord;
  logic [RESULT_W-1:0] w_next;

  assign en_get      = (r_state == IDLE) & ena & rdy_get;
  assign byte_out    = r_byte_out;
  assign byte_valid  = r_byte_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;
  assign aborted     = r_aborted;
  assign w_ord       = msb_first ? w_rev : get_data;
  assign w_next      = r_shift >> 8;

  // Byte-reverse the incoming word so the shift register always streams from its low byte
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < NBYTES; i++) w_rev[8*i +: 8] = get_data[RESULT_W-8-8*i +: 8];
  end

  // Two-state fetch/send FSM with registered outputs; abort wins over a final ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_byte_out    <= 8'h00;
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= 8'h00;
      r_aborted     <= 1'b0;
    end else begin
      r_aborted <= 1'b0;
      if (r_state == IDLE) begin
        if (en_get) begin
          r_state       <= SEND;
          r_shift       <= w_ord;
          r_cnt         <= '0;
          r_byte_out    <= w_ord[7:0];
          r_byte_valid  <= 1'b1;
          r_frame_start <= 1'b1;
          r_busy        <= 1'b1;
        end
      end else if (!ena || (byte_ack && r_cnt == LAST)) begin
        r_state       <= IDLE;
        r_shift       <= '0;
        r_cnt         <= '0;
        r_byte_out    <= 8'h00;
        r_byte_valid  <= 1'b0;
        r_frame_start <= 1'b0;
        r_busy        <= 1'b0;
        r_aborted     <= !ena;
        if (ena) r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (byte_ack) begin
        r_shift       <= w_next;
        r_cnt         <= r_cnt + 1'b1;
        r_byte_out    <= w_next[7:0];
        r_frame_start <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_herald_result_reader.sv
// tb_herald_result_reader: directed self-checking bench for herald_result_reader
module tb_herald_result_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        rdy_get = 1'b0;
  logic [31:0] get_data = 32'h0;
  logic        en_get;
  logic        msb_first = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ack = 1'b0;
  logic        frame_start;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        aborted;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  lsb_seq [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0]  msb_seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  herald_result_reader #(.RESULT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy_get(rdy_get), .get_data(get_data),
    .en_get(en_get), .msb_first(msb_first), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ack(byte_ack), .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_byte(input string tag, input logic [7:0] b, input logic fs);
    check({tag, "_valid"}, {31'h0, byte_valid}, 32'h1);
    check({tag, "_byte"}, {24'h0, byte_out}, {24'h0, b});
    check({tag, "_fs"}, {31'h0, frame_start}, {31'h0, fs});
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
  endtask

  task automatic check_idle(input string tag, input logic [7:0] cnt, input logic ab);
    check({tag, "_valid"}, {31'h0, byte_valid}, 32'h0);
    check({tag, "_byte"}, {24'h0, byte_out}, 32'h0);
    check({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_cnt"}, {24'h0, frame_cnt}, {24'h0, cnt});
    check({tag, "_abort"}, {31'h0, aborted}, {31'h0, ab});
  endtask

  // fast frame: capture, then ack each byte; rdy_get dropped after capture
  task automatic quick_frame();
    rdy_get = 1'b1;
    byte_ack = 1'b1;
    tick();
    rdy_get = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    get_data = 32'h12345678;
    #12;
    check_idle("reset", 8'h00, 1'b0);
    check("reset_en_get", {31'h0, en_get}, 32'h0);
    rst_n = 1'b1;
    #7;
    // LSB-first, ack tied high
    ena = 1'b1; rdy_get = 1'b1; msb_first = 1'b0; byte_ack = 1'b1;
    #1;
    check("lsb_en_get", {31'h0, en_get}, 32'h1);
    tick();
    rdy_get = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lsb_en_get_low", {31'h0, en_get}, 32'h0);
      check_byte("lsb", lsb_seq[i], i == 0);
      tick();
    end
    check_idle("lsb_done", 8'h01, 1'b0);
    // MSB-first with 3-cycle backpressure; msb_first flips mid-frame
    msb_first = 1'b1; rdy_get = 1'b1; byte_ack = 1'b0;
    tick();
    rdy_get = 1'b0; msb_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) begin
        check_byte("msb_hold", msb_seq[i], i == 0);
        tick();
      end
      check_byte("msb_ack", msb_seq[i], i == 0);
      byte_ack = 1'b1;
      tick();
      byte_ack = 1'b0;
    end
    check_idle("msb_done", 8'h02, 1'b0);
    // abort after byte 34 is acked
    byte_ack = 1'b1; rdy_get = 1'b1;
    tick();
    rdy_get = 1'b0;
    tick();
    tick();
    check_byte("abort_pre34", 8'h34, 1'b0);
    tick();
    check_byte("abort_pre12", 8'h12, 1'b0);
    ena = 1'b0; byte_ack = 1'b0; rdy_get = 1'b1;
    tick();
    check_idle("abort", 8'h02, 1'b1);
    check("abort_gate_en_get", {31'h0, en_get}, 32'h0);
    tick();
    check_idle("abort_after", 8'h02, 1'b0);
    ena = 1'b1; byte_ack = 1'b1;
    tick();
    rdy_get = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_byte("restart", lsb_seq[i], i == 0);
      tick();
    end
    check_idle("restart_done", 8'h03, 1'b0);
    // abort coincident with final ack
    rdy_get = 1'b1;
    tick();
    rdy_get = 1'b0;
    repeat (3) tick();
    check_byte("simul_last", 8'h12, 1'b0);
    ena = 1'b0;
    tick();
    check_idle("simul", 8'h03, 1'b1);
    // wrap: 253 more frames takes the count from 3 through 255 to 0
    ena = 1'b1;
    repeat (252) quick_frame();
    check("wrap_255", {24'h0, frame_cnt}, 32'hff);
    quick_frame();
    check("wrap_0", {24'h0, frame_cnt}, 32'h00);
    // gating in IDLE
    rdy_get = 1'b0; ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gate_rdy", {31'h0, en_get}, 32'h0);
      tick();
    end
    check_idle("gate_rdy_idle", 8'h00, 1'b0);
    rdy_get = 1'b1; ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gate_ena", {31'h0, en_get}, 32'h0);
      tick();
    end
    check_idle("gate_ena_idle", 8'h00, 1'b0);
    // reset mid-frame, after one more completed frame
    ena = 1'b1;
    quick_frame();
    check("pre_reset_cnt", {24'h0, frame_cnt}, 32'h01);
    rdy_get = 1'b1;
    tick();
    rdy_get = 1'b0;
    tick();
    check_byte("pre_reset", 8'h56, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset", 8'h00, 1'b0);
    tick();
    check_idle("in_reset", 8'h00, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check_idle("post_reset", 8'h00, 1'b0);
    rdy_get = 1'b1;
    tick();
    check_byte("post_reset_fetch", 8'h78, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
